// File: rtl/exu_mdu_seq_if.sv
// Handshake/bus bundle between the EX stage and the M-extension sequencer.
// The master side is the pipeline (ID/EX operands, flush); the slave side is the MDU.
interface exu_mdu_seq_if #(
    parameter int XLEN = 64
);
    logic            i_valid;
    logic [2:0]      i_mdu_op;
    logic            i_mdu_word;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic [4:0]      i_rd_addr;
    logic            i_flush;
    logic            o_stall;
    logic            o_valid;
    logic [XLEN-1:0] o_rd_data;
    logic [4:0]      o_rd_addr;

    modport master (
        output i_valid, i_mdu_op, i_mdu_word, i_op1, i_op2, i_rd_addr, i_flush,
        input  o_stall, o_valid, o_rd_data, o_rd_addr
    );

    modport slave (
        input  i_valid, i_mdu_op, i_mdu_word, i_op1, i_op2, i_rd_addr, i_flush,
        output o_stall, o_valid, o_rd_data, o_rd_addr
    );
endinterface

// File: rtl/exu_mdu_seq.sv
// RV64M iterative multiply/divide sequencer (radix-2 shift-add mul, restoring div) with EX stall.
// Optional macro MDU_ZERO_SKIP_EN: multiplies with a zero operand complete in one cycle.
module exu_mdu_seq #(
    parameter int XLEN = 64
) (
    input logic          clk,
    input logic          rst_n,
    exu_mdu_seq_if.slave mdu
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              word_q;
    logic              neg_q;
    logic              neg_r;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_data;
    // Shared work registers: mul uses acc=product, sh_a=multiplicand, sh_b=multiplier;
    // div uses acc=partial remainder, sh_a=divisor, sh_b=dividend/quotient shift register.
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] sh_a;
    logic [XLEN-1:0]   sh_b;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] fit_word(input logic w, input logic [XLEN-1:0] v);
        return w ? sext32(v) : v;
    endfunction

    logic            sgn1, sgn2, s1, s2, is_div;
    logic            div_zero, div_ovf, mul_zero, special;
    logic [XLEN-1:0] x1, x2, m1, m2, sp_res, min_val;

    always_comb begin
        sgn1     = mdu.i_mdu_op inside {3'd1, 3'd2, 3'd4, 3'd6};
        sgn2     = mdu.i_mdu_op inside {3'd1, 3'd4, 3'd6};
        is_div   = mdu.i_mdu_op[2];
        x1       = mdu.i_mdu_word ? (sgn1 ? sext32(mdu.i_op1) : zext32(mdu.i_op1)) : mdu.i_op1;
        x2       = mdu.i_mdu_word ? (sgn2 ? sext32(mdu.i_op2) : zext32(mdu.i_op2)) : mdu.i_op2;
        s1       = sgn1 & x1[XLEN-1];
        s2       = sgn2 & x2[XLEN-1];
        m1       = s1 ? -x1 : x1;
        m2       = s2 ? -x2 : x2;
        min_val  = mdu.i_mdu_word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div & (x2 == '0);
        div_ovf  = is_div & ~mdu.i_mdu_op[0] & (x1 == min_val) & (x2 == '1);
`ifdef MDU_ZERO_SKIP_EN
        mul_zero = ~is_div & ((x1 == '0) | (x2 == '0));
`else
        mul_zero = 1'b0;
`endif
        special  = div_zero | div_ovf | mul_zero;
        sp_res   = '0;
        if (div_zero)
            sp_res = mdu.i_mdu_op[1] ? x1 : '1;
        else if (div_ovf)
            sp_res = mdu.i_mdu_op[1] ? '0 : x1;
    end

    logic [2*XLEN-1:0] mul_acc, prod_f;
    logic [XLEN:0]     r_sh, r_nx, dvsr;
    logic              ge;
    logic [XLEN-1:0]   q_nx, quot_f, rem_f, fin;

    always_comb begin
        mul_acc = acc + (sh_b[0] ? sh_a : '0);
        dvsr    = {1'b0, sh_a[XLEN-1:0]};
        r_sh    = {acc[XLEN-1:0], sh_b[XLEN-1]};
        ge      = (r_sh >= dvsr);
        r_nx    = ge ? (r_sh - dvsr) : r_sh;
        q_nx    = {sh_b[XLEN-2:0], ge};
        // Sign correction is folded into the final BUSY cycle so DONE only presents the result.
        prod_f  = neg_q ? -mul_acc : mul_acc;
        quot_f  = neg_q ? -q_nx : q_nx;
        rem_f   = neg_r ? -r_nx[XLEN-1:0] : r_nx[XLEN-1:0];
        if (op_q[2])
            fin = op_q[1] ? rem_f : quot_f;
        else
            fin = (op_q[1:0] == 2'd0) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
            acc     <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
        end else if (mdu.i_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (mdu.i_valid) begin
                    op_q    <= mdu.i_mdu_op;
                    word_q  <= mdu.i_mdu_word;
                    neg_q   <= s1 ^ s2;
                    neg_r   <= s1;
                    rd_addr <= mdu.i_rd_addr;
                    cnt     <= '0;
                    acc     <= '0;
                    if (special) begin
                        rd_data <= fit_word(mdu.i_mdu_word, sp_res);
                        state   <= DONE;
                    end else begin
                        state <= BUSY;
                        if (is_div) begin
                            sh_a <= {{XLEN{1'b0}}, m2};
                            // Word dividends are pre-aligned so 32 shifts consume exactly bits 31..0.
                            sh_b <= mdu.i_mdu_word ? (m1 << 32) : m1;
                        end else begin
                            sh_a <= {{XLEN{1'b0}}, m1};
                            sh_b <= m2;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (op_q[2]) begin
                        acc  <= {{XLEN{1'b0}}, r_nx[XLEN-1:0]};
                        sh_b <= q_nx;
                    end else begin
                        acc  <= mul_acc;
                        sh_a <= sh_a << 1;
                        sh_b <= sh_b >> 1;
                    end
                    if (cnt == (word_q ? CW'(31) : CW'(XLEN-1))) begin
                        rd_data <= fit_word(word_q, fin);
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mdu.o_valid   = (state == DONE) & ~mdu.i_flush;
    assign mdu.o_stall   = mdu.i_valid & ~mdu.o_valid;
    assign mdu.o_rd_data = rd_data;
    assign mdu.o_rd_addr = rd_addr;
endmodule

// File: tb/tb_exu_mdu_seq.sv
// Self-checking bench for exu_mdu_seq: directed RV64M cases plus randomized ops against an
// arithmetic reference model (SV * / % on wide values).
module tb_exu_mdu_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exu_mdu_seq_if #(.XLEN(64)) mdu();
    exu_mdu_seq #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .mdu(mdu));

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0]    p;
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [31:0]     r32;
        bit              ovf32, ovf64;
        sa = a; sb = b; ua = a; ub = b;
        sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        ovf64 = (a == MIN64) && (b == ONES);
        if (w) begin
            r32 = '0;
            case (op)
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: if (sb32 == 0) r32 = '1; else if (ovf32) r32 = 32'h8000_0000; else r32 = sa32 / sb32;
                3'd5: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
                3'd6: if (sb32 == 0) r32 = sa32; else if (ovf32) r32 = '0; else r32 = sa32 % sb32;
                3'd7: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
                default: r32 = '0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (op)
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            3'd4: if (sb == 0) return ONES; else if (ovf64) return MIN64; else return sa / sb;
            3'd5: if (ub == 0) return ONES; else return ua / ub;
            3'd6: if (sb == 0) return a; else if (ovf64) return '0; else return sa % sb;
            default: if (ub == 0) return a; else return ua % ub;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input bit w,
                                   input logic [63:0] a, input logic [63:0] b);
        bit z1, z2, ovf;
        z1  = w ? (a[31:0] == 0) : (a == 0);
        z2  = w ? (b[31:0] == 0) : (b == 0);
        ovf = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == ONES);
        if (op[2]) begin
            if (z2 || (!op[0] && ovf)) return 1;
        end else begin
`ifdef MDU_ZERO_SKIP_EN
            if (z1 || z2) return 1;
`endif
        end
        return (w ? 32 : 64) + 1;
    endfunction

    // Drives one op (accepted at the next posedge), waits for o_valid and checks everything.
    // b2b: called right at the DONE negedge of the previous op with i_valid still high.
    task automatic run_op(input logic [2:0] op, input bit w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input bit b2b,
                          input bit keep, input bit scramble, output logic [63:0] res);
        logic [63:0] exp;
        int          lat, cyc;
        exp = model(op, w, a, b);
        lat = exp_lat(op, w, a, b);
        mdu.i_valid = 1'b1; mdu.i_mdu_op = op; mdu.i_mdu_word = w;
        mdu.i_op1 = a; mdu.i_op2 = b; mdu.i_rd_addr = rd;
        if (b2b) begin
            #1 chk("stall_off_in_done", 64'(mdu.o_stall), 64'd0);
            @(negedge clk);
        end
        #1 chk("stall_at_accept", 64'(mdu.o_stall), 64'd1);
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mdu.o_valid) break;
            if (scramble) begin
                mdu.i_op1 = {$urandom, $urandom}; mdu.i_op2 = {$urandom, $urandom};
                mdu.i_mdu_op = 3'($urandom_range(0, 7));
            end
        end
        chk("valid_seen", 64'(mdu.o_valid), 64'd1);
        chk("latency", 64'(cyc), 64'(lat));
        chk("rd_data", mdu.o_rd_data, exp);
        chk("rd_addr", 64'(mdu.o_rd_addr), 64'(rd));
        chk("stall_in_done", 64'(mdu.o_stall), 64'd0);
        res = mdu.o_rd_data;
        if (!keep) begin
            mdu.i_valid = 1'b0;
            @(negedge clk);
            chk("valid_one_pulse", 64'(mdu.o_valid), 64'd0);
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($signed($urandom_range(0, 40)) - 20);
            2: return '0;
            3: return MIN64;
            4: return ONES;
            default: return {{32{1'b0}}, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] r;
        logic [2:0]  op;
        bit          w, saw;
        mdu.i_valid = 1'b0; mdu.i_mdu_op = '0; mdu.i_mdu_word = 1'b0;
        mdu.i_op1 = '0; mdu.i_op2 = '0; mdu.i_rd_addr = '0; mdu.i_flush = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(mdu.o_valid), 64'd0);
        chk("rst_data", mdu.o_rd_data, 64'd0);
        chk("rst_addr", 64'(mdu.o_rd_addr), 64'd0);
        chk("rst_stall", 64'(mdu.o_stall), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 0, 64'd3, -64'sd5, 5'd1, 0, 0, 0, r); chk("mul_3x-5", r, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'd3, 0, ONES, 64'd2, 5'd2, 0, 0, 1, r);    chk("mulhu", r, 64'd1);
        run_op(3'd1, 0, ONES, ONES, 5'd3, 0, 0, 0, r);     chk("mulh", r, 64'd0);
        run_op(3'd2, 0, ONES, 64'd2, 5'd4, 0, 0, 0, r);    chk("mulhsu", r, ONES);
        run_op(3'd4, 1, 64'd7, 64'd0, 5'd5, 0, 0, 0, r);   chk("divw_by0", r, ONES);
        run_op(3'd6, 1, 64'd7, 64'd0, 5'd6, 0, 0, 0, r);   chk("remw_by0", r, 64'd7);
        run_op(3'd4, 0, MIN64, ONES, 5'd7, 0, 0, 0, r);    chk("div_ovf", r, MIN64);
        run_op(3'd6, 0, MIN64, ONES, 5'd8, 0, 0, 0, r);    chk("rem_ovf", r, 64'd0);
        run_op(3'd4, 0, -64'sd7, 64'd2, 5'd9, 0, 0, 1, r); chk("div_-7/2", r, -64'sd3);
        run_op(3'd6, 0, -64'sd7, 64'd2, 5'd10, 0, 0, 0, r); chk("rem_-7/2", r, ONES);
        run_op(3'd5, 1, 64'hFFFF_FFFE, 64'd2, 5'd11, 0, 0, 0, r); chk("divuw", r, 64'h7FFF_FFFF);
        run_op(3'd0, 0, 64'd0, 64'd1234, 5'd12, 0, 0, 0, r); chk("mul_zero", r, 64'd0);

        run_op(3'd0, 0, 64'd11, 64'd13, 5'd13, 0, 1, 0, r);
        run_op(3'd4, 0, 64'd100, 64'd7, 5'd14, 1, 0, 0, r); chk("b2b_div", r, 64'd14);

        // Flush a divide mid-flight, then start a multiply the cycle after.
        mdu.i_valid = 1'b1; mdu.i_mdu_op = 3'd4; mdu.i_mdu_word = 1'b0;
        mdu.i_op1 = 64'd1000; mdu.i_op2 = 64'd3; mdu.i_rd_addr = 5'd15;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) mdu.i_flush = 1'b1;
            #1 chk("flush_busy_novalid", 64'(mdu.o_valid), 64'd0);
        end
        @(negedge clk);
        mdu.i_flush = 1'b0;
        chk("flush_no_valid", 64'(mdu.o_valid), 64'd0);
        run_op(3'd0, 0, 64'd6, 64'd7, 5'd16, 0, 0, 0, r); chk("after_flush_mul", r, 64'd42);

        // Flush arriving while DONE suppresses the pulse.
        mdu.i_valid = 1'b1; mdu.i_mdu_op = 3'd4; mdu.i_mdu_word = 1'b1;
        mdu.i_op1 = 64'd7; mdu.i_op2 = 64'd0; mdu.i_rd_addr = 5'd17;
        @(posedge clk);
        @(negedge clk);
        chk("done_valid_pre_flush", 64'(mdu.o_valid), 64'd1);
        mdu.i_flush = 1'b1;
        #1 chk("done_flush_valid", 64'(mdu.o_valid), 64'd0);
        chk("done_flush_stall", 64'(mdu.o_stall), 64'd1);
        @(negedge clk);
        mdu.i_flush = 1'b0; mdu.i_valid = 1'b0;
        #1 chk("after_done_flush", 64'(mdu.o_valid), 64'd0);
        @(negedge clk);

        // Reset in the middle of a multiply.
        mdu.i_valid = 1'b1; mdu.i_mdu_op = 3'd0; mdu.i_mdu_word = 1'b0;
        mdu.i_op1 = 64'd5; mdu.i_op2 = 64'd9; mdu.i_rd_addr = 5'd18;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        mdu.i_valid = 1'b0;
        #1 chk("midrst_valid", 64'(mdu.o_valid), 64'd0);
        chk("midrst_data", mdu.o_rd_data, 64'd0);
        chk("midrst_addr", 64'(mdu.o_rd_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (70) begin
            @(negedge clk);
            if (mdu.o_valid) saw = 1;
        end
        chk("midrst_no_valid", 64'(saw), 64'd0);

        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            if (w) op = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'(4 + $urandom_range(0, 3));
            else   op = 3'($urandom_range(0, 7));
            run_op(op, w, pick(), pick(), 5'($urandom), 0, 0, 1, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
